bcd_seq_display: RTL and testbench
==================================

Name: bcd_seq_display

Overview:
- Sequential, parametrised successor to the combinational BCD display block.
- Converts an N_BITS binary value to N_DIGITS packed BCD digits with the shift-add-3 (double-dabble) algorithm, one bit per clock, using a start/busy/done handshake.
- Replaces divide/modulo arithmetic, so it scales to wide inputs without large dividers.
- Registered digits drive one existing decoder_7_seg instance per digit; sits between the switch/counter logic and the board displays.

Parameters:
- N_BITS, 10, width of binary input; legal range 1..31.
- N_DIGITS, 4, number of BCD digits and 7-segment displays; legal range 1..9.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bin_in  input  N_BITS  unsigned binary value, sampled on the accepted start.
- start  input  1  conversion request; accepted only in IDLE.
- busy  output  1  high while a conversion is in progress (state SHIFT).
- done  output  1  one-cycle pulse when bcd_out/seg_out update.
- overflow  output  1  last converted value exceeded 10^N_DIGITS-1; held until next done.
- bcd_out  output  4*N_DIGITS  packed BCD, digit 0 (units) in [3:0].
- seg_out  output  7*N_DIGITS  segments; digit k in [7k+6:7k], bit order a..g as decoder_7_seg, active-low.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, overflow=0, bcd_out=0; seg_out shows "0" on every digit (or blank per the optional feature). Deassertion is synchronised in the block, with a 2-flop release.
- FSM states and transitions:
  - IDLE: start=1 on a clock edge loads bin_in into the shift register, clears the scratch BCD register and bit counter := N_BITS. Overflow flag := (bin_in > 10^N_DIGITS-1), compared at 32 bits. Next state SHIFT.
  - SHIFT: each cycle, every scratch digit >=5 gets +3, then {scratch, shift} shifts left by 1 and counter decrements. Exactly N_BITS SHIFT cycles, then DONE.
  - DONE: one cycle. bcd_out := scratch, or all digits 9 if the overflow flag is set (saturation); overflow output := flag; done=1. Next state IDLE.
- Latency: start sampled at edge 0 gives done high in the cycle after edge N_BITS+1, so N_BITS+2 cycles start-to-start minimum.
- busy is high exactly N_BITS cycles per conversion.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: back-to-back conversions, each re-sampling bin_in in IDLE.
- bin_in changes after acceptance have no effect on the running conversion.
- Scratch register is 4*N_DIGITS bits; carries beyond the top digit are discarded (covered by overflow saturation).
- bcd_out, overflow and seg_out change only in DONE and hold otherwise.
- seg_out is combinational from registered bcd_out through decoder_7_seg, so there is no added latency.
- Reset mid-conversion: conversion aborted, all outputs return to reset values, no done pulse.

Optional Feature:
- Macro: BCD_SEQ_BLANK_EN.
- Defined: leading-zero blanking. Any digit above the most significant nonzero digit drives seg_out 7'b1111111 (all off). Digit 0 is never blanked, so value 0 shows a single "0". At reset, digits 1..N_DIGITS-1 are blank. bcd_out is unaffected.
- Undefined: every digit always displayed, leading zeros shown.

Test Plan:
- N_BITS=10, N_DIGITS=4, bin_in=1023, start pulse -> busy high 10 cycles; done 12th cycle after start edge; bcd_out=16'h1023, overflow=0; seg_out digits show 1,0,2,3.
- bin_in=0 then bin_in=999, consecutive conversions -> bcd_out=16'h0000 then 16'h0999; exactly one done pulse each.
- N_DIGITS=3, N_BITS=10, bin_in=1000 -> bcd_out=12'h999, overflow=1. Next conversion bin_in=5 -> 12'h005, overflow=0.
- start with bin_in=512, then start pulses with bin_in=7 during busy -> single done; bcd_out=16'h0512.
- rst_n low at SHIFT cycle 4 of a conversion of 345 -> busy=0, bcd_out=0, no done. After release, start with 345 -> 16'h0345.
- BCD_SEQ_BLANK_EN defined, bin_in=7 -> digits 3..1 seg=7'b1111111, digit 0 shows 7. Undefined -> digits 3..1 show 0.

Source files
------------

// File: rtl/bcd_seq_display.sv
// bcd_seq_display: sequential double-dabble binary-to-BCD converter driving one 7-segment decoder per digit.
// Optional leading-zero blanking when BCD_SEQ_BLANK_EN is defined.
module decoder_7_seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module bcd_seq_display #(
  parameter int N_BITS   = 10,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_BITS-1:0]     bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic [7*N_DIGITS-1:0] seg_out
);
  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_BITS + 1);
  localparam logic [31:0] MAX = 32'(10 ** N_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t            state;
  logic [1:0]        rst_sync;
  logic              rst_i_n;
  logic [N_BITS-1:0] sh;
  logic [BW-1:0]     scr, adj;
  logic [CW-1:0]     cnt;
  logic              ovf_flag;
  logic [N_DIGITS-1:0] show;
  // Reset asserts immediately, releases after two clean edges.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i_n = rst_sync[1];
  always_comb begin
    adj = scr;
    for (int k = 0; k < N_DIGITS; k++)
      if (scr[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
  end
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
      sh       <= '0;
      scr      <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh       <= bin_in;
            scr      <= '0;
            cnt      <= CW'(N_BITS);
            ovf_flag <= 32'(bin_in) > MAX;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {scr, sh} <= {adj, sh} << 1;
          cnt       <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          bcd_out  <= ovf_flag ? {N_DIGITS{4'h9}} : scr;
          overflow <= ovf_flag;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BCD_SEQ_BLANK_EN
  always_comb begin
    logic seen;
    seen = 1'b0;
    show = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      seen    = seen | (bcd_out[4*k +: 4] != 4'd0) | (k == 0);
      show[k] = seen;
    end
  end
`else
  assign show = '1;
`endif
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    logic [6:0] raw;
    decoder_7_seg u_dec (.bcd(bcd_out[4*i +: 4]), .seg(raw));
    assign seg_out[7*i +: 7] = show[i] ? raw : 7'b1111111;
  end
endmodule

// File: tb/tb_bcd_seq_display.sv
// tb_bcd_seq_display: scoreboard bench for bcd_seq_display (4-digit and 3-digit instances).
module tb_bcd_seq_display;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  bin_in = '0, bin3 = '0;
  logic        start = 1'b0, start3 = 1'b0;
  logic        busy, done, overflow, busy3, done3, ovf3;
  logic [15:0] bcd_out;
  logic [27:0] seg_out;
  logic [11:0] bcd3;
  logic [20:0] seg3;
  int n_tests = 0, n_fail = 0;
  int q4[$], q3[$];

  bcd_seq_display #(.N_BITS(10), .N_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .start(start), .busy(busy),
    .done(done), .overflow(overflow), .bcd_out(bcd_out), .seg_out(seg_out));
  bcd_seq_display #(.N_BITS(10), .N_DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bin_in(bin3), .start(start3), .busy(busy3),
    .done(done3), .overflow(ovf3), .bcd_out(bcd3), .seg_out(seg3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] t [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return d < 10 ? t[d] : 7'b1111111;
  endfunction

  function automatic logic [63:0] to_bcd(input int v, input int nd);
    logic [63:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] seg_exp(input logic [63:0] b, input int nd);
    logic [63:0] r = '0;
    logic seen = 1'b0;
    for (int k = nd - 1; k >= 0; k--) begin
      seen = seen | (b[4*k +: 4] != 4'd0) | (k == 0);
`ifdef BCD_SEQ_BLANK_EN
      r[7*k +: 7] = seen ? seg7(b[4*k +: 4]) : 7'b1111111;
`else
      r[7*k +: 7] = seg7(b[4*k +: 4]);
`endif
    end
    return r;
  endfunction

  always @(negedge clk) if (done) begin
    int v;
    if (q4.size() == 0) chk("spurious_done4", 1, 0);
    else begin
      v = q4.pop_front();
      chk("bcd4", bcd_out, to_bcd(v, 4));
      chk("ovf4", overflow, 0);
      chk("seg4", seg_out, seg_exp(to_bcd(v, 4), 4));
    end
  end

  always @(negedge clk) if (done3) begin
    int v;
    logic [63:0] e;
    if (q3.size() == 0) chk("spurious_done3", 1, 0);
    else begin
      v = q3.pop_front();
      e = v > 999 ? 64'h999 : to_bcd(v, 3);
      chk("bcd3", bcd3, e);
      chk("ovf3", ovf3, v > 999);
      chk("seg3", seg3, seg_exp(e, 3));
    end
  end

  task automatic run4(input int val, input bit inject);
    int c = 1, nb = 0;
    @(negedge clk); bin_in = 10'(val); start = 1'b1; q4.push_back(val);
    @(negedge clk); start = 1'b0;
    while (!done && c < 40) begin
      nb += int'(busy);
      bin_in = inject ? 10'd7 : 10'($urandom_range(0, 1023));
      start = inject && busy;
      @(negedge clk); c++;
    end
    start = 1'b0;
    chk("latency4", c, 12);
    chk("busy_cycles4", nb, 10);
  endtask

  task automatic run3(input int val);
    int c = 1;
    @(negedge clk); bin3 = 10'(val); start3 = 1'b1; q3.push_back(val);
    @(negedge clk); start3 = 1'b0;
    while (!done3 && c < 40) begin @(negedge clk); c++; end
    chk("latency3", c, 12);
  endtask

  task automatic wait_done4();
    int c = 0;
    while (!done && c < 40) begin @(negedge clk); c++; end
    chk("done_timeout4", c < 40, 1);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_seg", seg_out, seg_exp(0, 4));
    chk("rst_seg3", seg3, seg_exp(0, 3));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run4(1023, 0);
    // start held high: back-to-back conversions, bin_in resampled in IDLE
    @(negedge clk); bin_in = 10'd0; start = 1'b1; q4.push_back(0); q4.push_back(999);
    @(negedge clk); bin_in = 10'd999;
    wait_done4();
    @(negedge clk); start = 1'b0;
    wait_done4();
    run4(512, 1);
    run4(7, 0);
    for (int i = 0; i < 4; i++) run4(int'($urandom_range(0, 1023)), 0);
    // reset in the middle of a conversion
    @(negedge clk); bin_in = 10'd345; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_bcd", bcd_out, 0);
    chk("abort_done", done, 0);
    chk("abort_seg", seg_out, seg_exp(0, 4));
    repeat (15) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run4(345, 0);
    run3(1000);
    run3(5);
    run3(1023);
    run3(999);
    repeat (20) @(negedge clk);
    chk("sb_empty4", q4.size(), 0);
    chk("sb_empty3", q3.size(), 0);
    chk("final_bcd4", bcd_out, 16'h0345);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
